// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and FSM encodings for the UART program loader
package loader_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h1C09_0000;
  localparam int          DATA_BITS     = 8;

  localparam logic [2:0] S_LEN  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CSUM = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_loader_rx.sv
// rtl/uart_loader_rx.sv - 8N1 receiver with 2-FF synchroniser and mid-bit sampling
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int             CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST = 3'(DATA_BITS - 1);

  logic          sync1_q, sync2_q, prev_q;
  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          valid_q, ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          // Edge rather than level, so a low stop bit cannot retrigger a start
          if (prev_q && !sync2_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (idx_q == LAST) state_q <= RX_STOP;
            else               idx_q   <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            valid_q <= sync2_q;
            ferr_q  <= !sync2_q;
            state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign rx_byte   = shift_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - boot loader: UART frame to 32-bit word writes; UART_LOADER_CHECKSUM_EN adds trailing checksum
module uart_loader
  import loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter int          MAX_WORDS    = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        reload,
  output logic [31:0] uart_data,
  output logic [31:0] uart_addr,
  output logic        uart_we,
  output logic        uart_done,
  output logic        load_err
);

`ifdef UART_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_AFTER = S_CSUM;
`else
  localparam logic [2:0] S_AFTER = S_DONE;
`endif

  logic [7:0] rx_byte;
  logic       rx_valid, frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  logic [2:0]  state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] n_q, n_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] asm_word;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign asm_word = {rx_byte, word_q[23:0]};

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (reload) begin
      state_d = S_LEN;
      bcnt_d  = '0;
      wcnt_d  = '0;
      addr_d  = BASE_ADDR - 32'd4;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        S_LEN: begin
          if (frame_err) begin
            state_d = S_ERR;
          end else if (rx_valid) begin
            word_d[8*bcnt_q +: 8] = rx_byte;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              n_d = asm_word;
              if (asm_word > 32'(MAX_WORDS)) state_d = S_ERR;
              else if (asm_word == 32'd0)    state_d = S_AFTER;
              else                           state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          // Completion is checked a cycle after the last strobe so done trails uart_we
          if (frame_err) begin
            state_d = S_ERR;
          end else if (wcnt_q == n_q) begin
            state_d = S_AFTER;
          end else if (rx_valid) begin
            word_d[8*bcnt_q +: 8] = rx_byte;
            bcnt_d = bcnt_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_d = csum_q + rx_byte;
`endif
            if (bcnt_q == 2'd3) begin
              data_d = asm_word;
              addr_d = addr_q + 32'd4;
              we_d   = 1'b1;
              wcnt_d = wcnt_q + 32'd1;
            end
          end
        end
`ifdef UART_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (frame_err)     state_d = S_ERR;
          else if (rx_valid) state_d = (rx_byte == csum_q) ? S_DONE : S_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN;
      bcnt_q  <= '0;
      word_q  <= '0;
      n_q     <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      addr_q  <= BASE_ADDR - 32'd4;
      we_q    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign uart_data = data_q;
  assign uart_addr = addr_q;
  assign uart_we   = we_q;
  assign uart_done = (state_q == S_DONE);
  assign load_err  = (state_q == S_ERR);

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - scoreboard bench for uart_loader with randomized frames
module tb_uart_loader;

  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h1C09_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        reload = 1'b0;
  logic [31:0] uart_data, uart_addr;
  logic        uart_we, uart_done, load_err;

  uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .reload    (reload),
    .uart_data (uart_data),
    .uart_addr (uart_addr),
    .uart_we   (uart_we),
    .uart_done (uart_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_count = 0;
  int last_we_cyc = -1;
  int done_rise_cyc = -1;
  logic prev_done = 1'b0;
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] frame_words[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the next expected word
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_we) begin
        we_count++;
        last_we_cyc = cyc;
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_we: data %h addr %h with empty scoreboard", uart_data, uart_addr);
        end else begin
          chk("we_data", uart_data, exp_data.pop_front());
          chk("we_addr", uart_addr, exp_addr.pop_front());
        end
      end
      if (uart_done && !prev_done) done_rise_cyc = cyc;
    end
    prev_done = uart_done;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(3, 0)) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  // Reference: frame = LE length, LE words, optional byte-sum checksum; word i lands at BASE+4i
  task automatic send_frame(input bit push_exp);
    logic [7:0] sum;
    logic [31:0] w;
    sum = 8'd0;
    send_word(32'(frame_words.size()));
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      if (push_exp) begin
        exp_data.push_back(w);
        exp_addr.push_back(BASE + 32'(4 * i));
      end
      sum = sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
      send_word(w);
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(sum, 1'b1);
`endif
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, uart_data, 32'd0);
    chk({tag, "_addr"}, uart_addr, BASE - 32'd4);
    chk({tag, "_we"},   32'(uart_we), 32'd0);
    chk({tag, "_done"}, 32'(uart_done), 32'd0);
    chk({tag, "_err"},  32'(load_err), 32'd0);
  endtask

  initial begin
    int we0;
    int nw;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Two-word frame from the test plan
    we0 = we_count;
    frame_words = '{32'h1122_3344, 32'hAABB_CCDD};
    send_frame(1'b1);
    chk("two_word_done", 32'(uart_done), 32'd1);
    chk("two_word_err", 32'(load_err), 32'd0);
    chk("two_word_we_count", 32'(we_count - we0), 32'd2);
`ifndef UART_LOADER_CHECKSUM_EN
    chk("done_after_last_we", 32'(done_rise_cyc), 32'(last_we_cyc + 1));
`endif
    chk("data_holds", uart_data, 32'hAABB_CCDD);

    // Empty frame
    do_reload();
    chk("reload_clears_done", 32'(uart_done), 32'd0);
    chk("reload_addr", uart_addr, BASE - 32'd4);
    we0 = we_count;
    frame_words = {};
    send_frame(1'b0);
    chk("empty_done", 32'(uart_done), 32'd1);
    chk("empty_no_we", 32'(we_count - we0), 32'd0);

    // Framing error mid-word, then recovery
    do_reload();
    send_word(32'd1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (4) @(negedge clk);
    chk("ferr_err", 32'(load_err), 32'd1);
    chk("ferr_done", 32'(uart_done), 32'd0);
    do_reload();
    chk("ferr_reload_err", 32'(load_err), 32'd0);
    frame_words = '{32'hCAFE_F00D};
    send_frame(1'b1);
    chk("recover_done", 32'(uart_done), 32'd1);
    chk("recover_err", 32'(load_err), 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
    do_reload();
    exp_data.push_back(32'h0403_0201);
    exp_addr.push_back(BASE);
    send_word(32'd1);
    send_word(32'h0403_0201);
    send_byte(8'h0A, 1'b1);
    repeat (4) @(negedge clk);
    chk("csum_ok_done", 32'(uart_done), 32'd1);
    chk("csum_ok_err", 32'(load_err), 32'd0);
    do_reload();
    exp_data.push_back(32'h0403_0201);
    exp_addr.push_back(BASE);
    send_word(32'd1);
    send_word(32'h0403_0201);
    send_byte(8'h0B, 1'b1);
    repeat (4) @(negedge clk);
    chk("csum_bad_err", 32'(load_err), 32'd1);
    chk("csum_bad_done", 32'(uart_done), 32'd0);
`endif

    // Length one above the limit
    do_reload();
    we0 = we_count;
    send_word(32'h0000_4001);
    repeat (4) @(negedge clk);
    chk("len_err", 32'(load_err), 32'd1);
    chk("len_no_we", 32'(we_count - we0), 32'd0);

    // Asynchronous reset mid-word
    do_reload();
    send_word(32'd1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    frame_words = '{$urandom()};
    send_frame(1'b1);
    chk("post_rst_done", 32'(uart_done), 32'd1);
    chk("post_rst_addr", uart_addr, BASE);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      do_reload();
      nw = $urandom_range(4, 1);
      frame_words = {};
      for (int i = 0; i < nw; i++) frame_words.push_back($urandom());
      we0 = we_count;
      send_frame(1'b1);
      chk("rand_done", 32'(uart_done), 32'd1);
      chk("rand_err", 32'(load_err), 32'd0);
      chk("rand_we_count", 32'(we_count - we0), 32'(nw));
      chk("rand_last_addr", uart_addr, BASE + 32'(4 * (nw - 1)));
    end

    // Bytes after done are ignored
    send_word(32'h1234_5678);
    repeat (4) @(negedge clk);
    chk("post_done_still_done", 32'(uart_done), 32'd1);
    chk("scoreboard_empty", 32'(exp_data.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
